// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
package lsu_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      DONE,
      ERR
   } lsu_state_e;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'b00,
      ERR_MISALIGN = 2'b01,
      ERR_TIMEOUT  = 2'b10,
      ERR_BE       = 2'b11
   } lsu_err_e;

   localparam logic [3:0] BE_BYTE = 4'b0001;
   localparam logic [3:0] BE_HALF = 4'b0011;
   localparam logic [3:0] BE_WORD = 4'b1111;

   // Replicate store data so every lane carries the right bytes.
   function automatic logic [31:0] lsu_store_data(
      input logic [3:0]  be,
      input logic [31:0] d
   );
      logic [31:0] r;
      r = d;
      if (be == BE_BYTE) begin
         r = {4{d[7:0]}};
      end else if (be == BE_HALF) begin
         r = {2{d[15:0]}};
      end
      return r;
   endfunction

   function automatic lsu_err_e lsu_check(
      input logic [3:0] be,
      input logic [1:0] lane
   );
      lsu_err_e e;
      e = ERR_NONE;
      if ((be == BE_HALF && lane[0]) ||
          (be == BE_WORD && lane != 2'b00)) begin
         e = ERR_MISALIGN;
      end else if (be != BE_BYTE && be != BE_HALF &&
                   be != BE_WORD) begin
         e = ERR_BE;
      end
      return e;
   endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Load lane select plus zero/sign extension.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  lane_i,
   input  logic [3:0]  be_i,
   input  logic        sign_ext_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = rdata_i[{lane_i, 3'b000} +: 8];
      half_v = rdata_i[{lane_i[1], 4'b0000} +: 16];
      data_o = rdata_i;
      if (be_i == BE_BYTE) begin
         data_o = {{24{sign_ext_i & byte_v[7]}}, byte_v};
      end else if (be_i == BE_HALF) begin
         data_o = {{16{sign_ext_i & half_v[15]}}, half_v};
      end
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: request register, access FSM, timeout
// counter and store/load lane alignment.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        wr_en_i,
   input  logic [3:0]  byte_en_i,
   input  logic        sign_ext_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wr_data_i,
   input  logic [4:0]  rd_idx_i,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic        done_o,
   output logic        rf_wr_en_o,
   output logic [4:0]  rf_rd_o,
   output logic [31:0] rf_data_o,
   output logic [1:0]  err_o
);

   localparam int unsigned CNT_W =
      (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'(TIMEOUT_CYCLES - 1);
   localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

   lsu_state_e       state_q, state_d;
   lsu_err_e         err_q, err_d;
   lsu_err_e         chk_err;
   logic [29:0]      word_q, word_d;
   logic [1:0]       lane_q, lane_d;
   logic [3:0]       be_q, be_d;
   logic [31:0]      wdata_q, wdata_d;
   logic             sign_q, sign_d;
   logic [4:0]       rd_q, rd_d;
   logic             we_q, we_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      data_q, data_d;
   logic [31:0]      ld_data;

   logic             ready_q, ready_d;
   logic             mreq_q, mreq_d;
   logic             mwe_q, mwe_d;
   logic [31:0]      maddr_q, maddr_d;
   logic [3:0]       mbe_q, mbe_d;
   logic [31:0]      mwdata_q, mwdata_d;
   logic             done_q, done_d;
   logic             rfwe_q, rfwe_d;
   logic [4:0]       rfrd_q, rfrd_d;
   logic [31:0]      rfdata_q, rfdata_d;
   lsu_err_e         errout_q, errout_d;

   lsu_load_align u_align (
      .rdata_i    (mem_rdata_i),
      .lane_i     (lane_q),
      .be_i       (be_q),
      .sign_ext_i (sign_q),
      .data_o     (ld_data)
   );

   assign chk_err = lsu_check(byte_en_i, addr_i[1:0]);

   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      word_d  = word_q;
      lane_d  = lane_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      sign_d  = sign_q;
      rd_d    = rd_q;
      we_d    = we_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid_i) begin
               word_d  = addr_i[31:2];
               lane_d  = addr_i[1:0];
               be_d    = byte_en_i;
               wdata_d = lsu_store_data(byte_en_i, wr_data_i);
               sign_d  = sign_ext_i;
               rd_d    = rd_idx_i;
               we_d    = wr_en_i;
               err_d   = chk_err;
               state_d = (chk_err == ERR_NONE) ? REQ : ERR;
            end
         end
         REQ: begin
            if (mem_gnt_i) begin
               state_d = we_q ? DONE : WAIT;
               cnt_d   = '0;
            end
         end
         WAIT: begin
            if (mem_rvalid_i) begin
               data_d  = ld_data;
               state_d = DONE;
            end else if (TO_EN && cnt_q == CNT_LAST) begin
               err_d   = ERR_TIMEOUT;
               state_d = ERR;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: state_d = IDLE;
         ERR:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they leave a flop.
   always_comb begin
      ready_d  = (state_d == IDLE);
      mreq_d   = (state_d == REQ);
      mwe_d    = mreq_d & we_d;
      maddr_d  = mreq_d ? {word_d, 2'b00} : '0;
      mbe_d    = mreq_d ? (be_d << lane_d) : '0;
      mwdata_d = (mreq_d & we_d) ? wdata_d : '0;
      done_d   = (state_d == DONE) || (state_d == ERR);
      rfwe_d   = (state_d == DONE) & ~we_d;
      rfrd_d   = rfwe_d ? rd_d : '0;
      rfdata_d = rfwe_d ? data_d : '0;
      errout_d = (state_d == ERR) ? err_d : ERR_NONE;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= IDLE;
         err_q    <= ERR_NONE;
         word_q   <= '0;
         lane_q   <= '0;
         be_q     <= '0;
         wdata_q  <= '0;
         sign_q   <= 1'b0;
         rd_q     <= '0;
         we_q     <= 1'b0;
         cnt_q    <= '0;
         data_q   <= '0;
         ready_q  <= 1'b1;
         mreq_q   <= 1'b0;
         mwe_q    <= 1'b0;
         maddr_q  <= '0;
         mbe_q    <= '0;
         mwdata_q <= '0;
         done_q   <= 1'b0;
         rfwe_q   <= 1'b0;
         rfrd_q   <= '0;
         rfdata_q <= '0;
         errout_q <= ERR_NONE;
      end else begin
         state_q  <= state_d;
         err_q    <= err_d;
         word_q   <= word_d;
         lane_q   <= lane_d;
         be_q     <= be_d;
         wdata_q  <= wdata_d;
         sign_q   <= sign_d;
         rd_q     <= rd_d;
         we_q     <= we_d;
         cnt_q    <= cnt_d;
         data_q   <= data_d;
         ready_q  <= ready_d;
         mreq_q   <= mreq_d;
         mwe_q    <= mwe_d;
         maddr_q  <= maddr_d;
         mbe_q    <= mbe_d;
         mwdata_q <= mwdata_d;
         done_q   <= done_d;
         rfwe_q   <= rfwe_d;
         rfrd_q   <= rfrd_d;
         rfdata_q <= rfdata_d;
         errout_q <= errout_d;
      end
   end

   assign req_ready_o = ready_q;
   assign mem_req_o   = mreq_q;
   assign mem_we_o    = mwe_q;
   assign mem_addr_o  = maddr_q;
   assign mem_be_o    = mbe_q;
   assign mem_wdata_o = mwdata_q;
   assign done_o      = done_q;
   assign rf_wr_en_o  = rfwe_q;
   assign rf_rd_o     = rfrd_q;
   assign rf_data_o   = rfdata_q;
   assign err_o       = errout_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a behavioural
// model of alignment, extension, legality and timing.
module tb_load_store_unit;

   localparam int TO = 4;

   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic        wr_en_i = 1'b0;
   logic [3:0]  byte_en_i = '0;
   logic        sign_ext_i = 1'b0;
   logic [31:0] addr_i = '0;
   logic [31:0] wr_data_i = '0;
   logic [4:0]  rd_idx_i = '0;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_wdata_o;
   logic        mem_gnt_i = 1'b0;
   logic        mem_rvalid_i = 1'b0;
   logic [31:0] mem_rdata_i = '0;
   logic        done_o;
   logic        rf_wr_en_o;
   logic [4:0]  rf_rd_o;
   logic [31:0] rf_data_o;
   logic [1:0]  err_o;

   int n_chk = 0;
   int n_fail = 0;

   load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .wr_en_i      (wr_en_i),
      .byte_en_i    (byte_en_i),
      .sign_ext_i   (sign_ext_i),
      .addr_i       (addr_i),
      .wr_data_i    (wr_data_i),
      .rd_idx_i     (rd_idx_i),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_be_o     (mem_be_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i),
      .done_o       (done_o),
      .rf_wr_en_o   (rf_wr_en_o),
      .rf_rd_o      (rf_rd_o),
      .rf_data_o    (rf_data_o),
      .err_o        (err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t",
                  tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic int exp_err(input int unsigned be,
                                  input int unsigned addr);
      if (be == 3 && addr % 2 != 0) return 1;
      if (be == 15 && addr % 4 != 0) return 1;
      if (be != 1 && be != 3 && be != 15) return 3;
      return 0;
   endfunction

   function automatic int unsigned exp_be(input int unsigned be,
                                          input int unsigned addr);
      return (be * (1 << (addr % 4))) % 16;
   endfunction

   function automatic int unsigned exp_wd(input int unsigned be,
                                          input int unsigned wd);
      if (be == 1) return (wd % 256) * 32'h0101_0101;
      if (be == 3) return (wd % 65536) * 32'h0001_0001;
      return wd;
   endfunction

   function automatic int unsigned exp_ld(input int unsigned be,
                                          input bit sx,
                                          input int unsigned addr,
                                          input int unsigned rd);
      int unsigned v;
      if (be == 1) begin
         v = (rd / (1 << (8 * (addr % 4)))) % 256;
         if (sx && v >= 128) v = v + 32'hFFFF_FF00;
      end else if (be == 3) begin
         v = (rd / (1 << (16 * ((addr / 2) % 2)))) % 65536;
         if (sx && v >= 32768) v = v + 32'hFFFF_0000;
      end else begin
         v = rd;
      end
      return v;
   endfunction

   task automatic run_acc(input bit we, input logic [3:0] be,
                          input bit sx, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [4:0] rd,
                          input int gd, input int rdl,
                          input logic [31:0] rdata);
      int e;
      e = exp_err(be, addr);
      chk("ready_idle", req_ready_o, 1);
      req_valid_i = 1'b1;
      wr_en_i = we;
      byte_en_i = be;
      sign_ext_i = sx;
      addr_i = addr;
      wr_data_i = wd;
      rd_idx_i = rd;
      tick();
      req_valid_i = 1'b0;
      addr_i = $urandom;
      wr_data_i = $urandom;
      if (e != 0) begin
         chk("err_mreq", mem_req_o, 0);
         chk("err_done", done_o, 1);
         chk("err_code", err_o, 32'(e));
         chk("err_rfwe", rf_wr_en_o, 0);
         tick();
         chk("err_after", done_o, 0);
         return;
      end
      for (int i = 0; i <= gd; i++) begin
         chk("mreq", mem_req_o, 1);
         chk("maddr", mem_addr_o, addr & 32'hFFFF_FFFC);
         chk("mbe", mem_be_o, exp_be(be, addr));
         chk("mwe", mem_we_o, 32'(we));
         if (we) chk("mwdata", mem_wdata_o, exp_wd(be, wd));
         chk("busy", req_ready_o, 0);
         chk("nodone", done_o, 0);
         mem_gnt_i = (i == gd);
         tick();
      end
      mem_gnt_i = 1'b0;
      if (we) begin
         chk("st_done", done_o, 1);
         chk("st_rfwe", rf_wr_en_o, 0);
         chk("st_err", err_o, 0);
      end else begin
         chk("wait_mreq", mem_req_o, 0);
         for (int i = 0; i < rdl && i < TO; i++) begin
            chk("wait_done", done_o, 0);
            mem_rdata_i = $urandom;
            tick();
         end
         if (rdl >= TO) begin
            chk("to_done", done_o, 1);
            chk("to_err", err_o, 2);
            chk("to_rfwe", rf_wr_en_o, 0);
         end else begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i = rdata;
            tick();
            mem_rvalid_i = 1'b0;
            mem_rdata_i = $urandom;
            chk("ld_done", done_o, 1);
            chk("ld_rfwe", rf_wr_en_o, 1);
            chk("ld_rd", rf_rd_o, 32'(rd));
            chk("ld_data", rf_data_o, exp_ld(be, sx, addr, rdata));
            chk("ld_err", err_o, 0);
         end
      end
      tick();
      chk("post_done", done_o, 0);
      chk("post_rfwe", rf_wr_en_o, 0);
   endtask

   logic [3:0] be_tab [10] = '{4'h1, 4'h3, 4'hF, 4'h1, 4'h3,
                               4'hF, 4'h0, 4'h2, 4'h5, 4'hC};

   initial begin
      #12;
      chk("rst_ready", req_ready_o, 1);
      chk("rst_mreq", mem_req_o, 0);
      chk("rst_maddr", mem_addr_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_rfwe", rf_wr_en_o, 0);
      chk("rst_err", err_o, 0);
      rst_n_i = 1'b1;
      tick();

      run_acc(0, 4'h1, 1, 32'h103, 0, 5'd7, 0, 0, 32'h80FF_FFFF);
      run_acc(0, 4'h3, 0, 32'h102, 0, 5'd9, 0, 0, 32'h8001_1234);
      run_acc(1, 4'h1, 0, 32'h201, 32'hAB, 5'd3, 0, 0, 0);
      run_acc(0, 4'hF, 0, 32'h2, 0, 5'd1, 0, 0, 0);
      run_acc(1, 4'h3, 0, 32'h5, 32'h1234, 5'd1, 0, 0, 0);
      run_acc(0, 4'h6, 0, 32'h0, 0, 5'd1, 0, 0, 0);
      run_acc(0, 4'hF, 0, 32'h40, 0, 5'd12, 3, 1, 32'hDEAD_BEEF);
      run_acc(0, 4'h3, 1, 32'h40, 0, 5'd2, 0, TO - 1, 32'h0000_9001);
      run_acc(0, 4'hF, 0, 32'h80, 0, 5'd4, 0, TO + 2, 0);

      mem_gnt_i = 1'b1;
      mem_rvalid_i = 1'b1;
      tick();
      mem_gnt_i = 1'b0;
      mem_rvalid_i = 1'b0;
      chk("idle_gnt_req", mem_req_o, 0);
      chk("idle_rv_done", done_o, 0);

      req_valid_i = 1'b1;
      wr_en_i = 1'b0;
      byte_en_i = 4'hF;
      addr_i = 32'h100;
      tick();
      req_valid_i = 1'b0;
      mem_gnt_i = 1'b1;
      tick();
      mem_gnt_i = 1'b0;
      tick();
      #2 rst_n_i = 1'b0;
      #1;
      chk("rst_mid_ready", req_ready_o, 1);
      chk("rst_mid_done", done_o, 0);
      mem_rvalid_i = 1'b1;
      #2 rst_n_i = 1'b1;
      tick();
      mem_rvalid_i = 1'b0;
      chk("rst_drop_done", done_o, 0);
      chk("rst_drop_mreq", mem_req_o, 0);
      tick();

      for (int n = 0; n < 200; n++) begin
         run_acc($urandom_range(0, 1), be_tab[$urandom_range(0, 9)],
                 $urandom_range(0, 1), $urandom, $urandom,
                 5'($urandom), $urandom_range(0, 3),
                 $urandom_range(0, 5), $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
